mul_div_ctrl: RTL

Sequencer between the EX stage and the shared iterative multiply/divide unit. Accepts one-hot mul/div requests from EX, issues them to the unit with a start/done handshake, and raises `stallreq` until the result is ready. It holds the result while the pipeline is stalled and drains in-flight operations on flush. An optional last-result cache serves a repeated operand pair, such as div followed by mod, without re-issuing.

---
 rtl/mul_div_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_ctrl.sv
// Sequencer between EX and the shared iterative multiply/divide unit.
// Optional last-result cache enabled by defining MUL_DIV_CTRL_REUSE_EN.
module mul_div_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [3:0]       ex_op,
    input  logic             ex_sign,
    input  logic [31:0]      ex_a,
    input  logic [31:0]      ex_b,
    output logic             stallreq,
    output logic [31:0]      result,
    output logic             unit_start,
    output logic             unit_div,
    output logic             unit_sign,
    output logic [31:0]      unit_a,
    output logic [31:0]      unit_b,
    input  logic             unit_done,
    input  logic [31:0]      unit_lo,
    input  logic [31:0]      unit_hi,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       w_op_sel;
    logic             w_req;
    logic             w_div;
    logic             w_hi_sel;
    logic             w_issue;
    logic             w_hold;
    logic             w_hit;
    logic [31:0]      w_hit_val;
    logic             w_unused;

    logic             r_key_div;
    logic             r_key_sign;
    logic [31:0]      r_key_a;
    logic [31:0]      r_key_b;
    logic             r_hi_sel;
    logic [31:0]      r_res_lo;
    logic [31:0]      r_res_hi;
    logic [CNT_W-1:0] r_perf;

    // Multi-hot ops resolve to the lowest set bit.
    assign w_op_sel = ex_op & (~ex_op + 4'd1);
    assign w_req    = ex_valid & (|ex_op) & ~flush;
    assign w_div    = w_op_sel[2] | w_op_sel[3];
    assign w_hi_sel = w_op_sel[1] | w_op_sel[3];
    assign w_unused = ^{stall[5:3], stall[1:0]};

`ifdef MUL_DIV_CTRL_REUSE_EN
    logic        r_c_valid;
    logic        r_c_div;
    logic        r_c_sign;
    logic [31:0] r_c_a;
    logic [31:0] r_c_b;
    logic [31:0] r_c_lo;
    logic [31:0] r_c_hi;

    assign w_hit = (r_state == S_IDLE) & w_req & r_c_valid & (r_c_div == w_div) &
                   (r_c_sign == ex_sign) & (r_c_a == ex_a) & (r_c_b == ex_b);
    assign w_hit_val = w_hi_sel ? r_c_hi : r_c_lo;

    // A flushed op completing in BUSY still refreshes the cache; one in DRAIN does not.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_c_valid <= 1'b0;
            r_c_div   <= 1'b0;
            r_c_sign  <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_lo    <= '0;
            r_c_hi    <= '0;
        end else if ((r_state == S_BUSY) && unit_done) begin
            r_c_valid <= 1'b1;
            r_c_div   <= r_key_div;
            r_c_sign  <= r_key_sign;
            r_c_a     <= r_key_a;
            r_c_b     <= r_key_b;
            r_c_lo    <= unit_lo;
            r_c_hi    <= unit_hi;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_val = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        stallreq    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_issue     = 1'b1;
                    stallreq    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stallreq = 1'b1;
                if (unit_done) w_state_nxt = flush ? S_IDLE : S_DONE;
                else if (flush) w_state_nxt = S_DRAIN;
            end
            S_DONE: begin
                if (!stall[2] || flush) w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                // The unit cannot abort: new work waits here instead of issuing.
                stallreq = w_req;
                if (unit_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_hold     = (r_state == S_BUSY) || (r_state == S_DRAIN);
    assign unit_start = w_issue;
    assign unit_div   = w_issue ? w_div   : (w_hold ? r_key_div  : 1'b0);
    assign unit_sign  = w_issue ? ex_sign : (w_hold ? r_key_sign : 1'b0);
    assign unit_a     = w_issue ? ex_a    : (w_hold ? r_key_a    : 32'd0);
    assign unit_b     = w_issue ? ex_b    : (w_hold ? r_key_b    : 32'd0);

    assign result = (r_state == S_DONE) ? (r_hi_sel ? r_res_hi : r_res_lo)
                                        : (w_hit ? w_hit_val : 32'd0);
    assign perf_stall_cnt = r_perf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_key_div  <= 1'b0;
            r_key_sign <= 1'b0;
            r_key_a    <= '0;
            r_key_b    <= '0;
            r_hi_sel   <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_perf     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_key_div  <= w_div;
                r_key_sign <= ex_sign;
                r_key_a    <= ex_a;
                r_key_b    <= ex_b;
                r_hi_sel   <= w_hi_sel;
            end
            if ((r_state == S_BUSY) && unit_done && !flush) begin
                r_res_lo <= unit_lo;
                r_res_hi <= unit_hi;
            end
            if (stallreq && (r_perf != {CNT_W{1'b1}})) r_perf <= r_perf + CNT_W'(1);
        end
    end

endmodule
